// File: rtl/midi_kp_ctrl.sv
// rtl/midi_kp_ctrl.sv - MIDI note parser driving a Karplus-Strong voice trigger
module midi_kp_ctrl #(
  parameter int TRIG_LEN  = 16,
  parameter int MIN_DELAY = 8
) (
  input  logic       a_clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [3:0] midi_chan,
  input  logic       omni,
  output logic       trig,
  output logic [6:0] velocity,
  output logic [9:0] delay_length,
  output logic [6:0] note,
  output logic       note_active
);

  typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_HIGH, T_GAP} t_state_t;

  localparam logic [9:0] RESET_DELAY = 10'd734;
  localparam logic [9:0] MIN_D       = 10'(MIN_DELAY);
  localparam logic [7:0] CNT_LAST    = 8'(TRIG_LEN - 1);

  p_state_t   p_state, p_next;
  t_state_t   t_state, t_next;
  logic [7:0] cnt, cnt_next;

  logic       rs_valid, rs_on;
  logic [6:0] p_note;
  logic       msg_done, msg_done_q, msg_on;
  logic [6:0] msg_note, msg_vel;
  logic       take_note;

  logic       pend;
  logic [6:0] pd_note, pd_vel;
  logic [9:0] pd_delay;
  logic       load, cancel, off_hit;

  // Byte classification; realtime bytes fall through every branch untouched
  logic is_rt, is_status, is_data, note_status;
  assign is_rt       = rx_valid && (rx_data >= 8'hF8);
  assign is_status   = rx_valid && rx_data[7] && !is_rt;
  assign is_data     = rx_valid && !rx_data[7];
  assign note_status = (rx_data[7:5] == 3'b100) && (omni || (rx_data[3:0] == midi_chan));

  // Loop length for a note: octave shifts the base table down from note 48
  function automatic logic [9:0] kp_delay(input logic [6:0] n);
    logic [6:0] m;
    logic [3:0] k;
    logic [2:0] o;
    logic [9:0] base;
    logic [9:0] d;
    m = n - 7'd48;
    if (n >= 7'd48) begin
      k = 4'(m % 7'd12);
      o = 3'(m / 7'd12);
    end else begin
      k = 4'(n % 7'd12);
      o = 3'd0;
    end
    case (k)
      4'd0:    base = 10'd734;
      4'd1:    base = 10'd693;
      4'd2:    base = 10'd654;
      4'd3:    base = 10'd617;
      4'd4:    base = 10'd582;
      4'd5:    base = 10'd550;
      4'd6:    base = 10'd519;
      4'd7:    base = 10'd490;
      4'd8:    base = 10'd462;
      4'd9:    base = 10'd436;
      4'd10:   base = 10'd412;
      default: base = 10'd389;
    endcase
    d = base >> o;
    if (d < MIN_D) d = MIN_D;
    return d;
  endfunction

  // Parser state register
  always_ff @(posedge a_clk) begin
    if (!reset_n) p_state <= P_IDLE;
    else          p_state <= p_next;
  end

  // Parser next state
  always_comb begin
    p_next = p_state;
    if (is_status) begin
      p_next = note_status ? P_DATA1 : P_IDLE;
    end else if (is_data) begin
      case (p_state)
        P_IDLE:  p_next = rs_valid ? P_DATA2 : P_IDLE;
        P_DATA1: p_next = P_DATA2;
        default: p_next = P_IDLE;
      endcase
    end
  end

  // Parser strobes: capture the note byte, or complete the message
  always_comb begin
    take_note = is_data && ((p_state == P_IDLE && rs_valid) || p_state == P_DATA1);
    msg_done  = is_data && (p_state == P_DATA2);
  end

  // Running status and the completed-message register
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      rs_valid   <= 1'b0;
      rs_on      <= 1'b0;
      p_note     <= 7'd0;
      msg_done_q <= 1'b0;
      msg_note   <= 7'd0;
      msg_vel    <= 7'd0;
      msg_on     <= 1'b0;
    end else begin
      msg_done_q <= msg_done;
      if (is_status) begin
        rs_valid <= note_status;
        rs_on    <= rx_data[4];
      end
      if (take_note) p_note <= rx_data[6:0];
      if (msg_done) begin
        msg_note <= p_note;
        msg_vel  <= rx_data[6:0];
        msg_on   <= rs_on && (rx_data[6:0] != 7'd0);
      end
    end
  end

  assign cancel  = msg_done_q && !msg_on && pend && (msg_note == pd_note);
  assign off_hit = msg_done_q && !msg_on && (msg_note == note);

  // Pending slot: newest note-on wins, a matching note-off drops it
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      pend     <= 1'b0;
      pd_note  <= 7'd0;
      pd_vel   <= 7'd0;
      pd_delay <= RESET_DELAY;
    end else if (msg_done_q && msg_on) begin
      pend     <= 1'b1;
      pd_note  <= msg_note;
      pd_vel   <= msg_vel;
      pd_delay <= kp_delay(msg_note);
    end else if (load || cancel) begin
      pend <= 1'b0;
    end
  end

  // Trigger state and pulse/gap counter register
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      t_state <= T_IDLE;
      cnt     <= 8'd0;
    end else begin
      t_state <= t_next;
      cnt     <= cnt_next;
    end
  end

  // Trigger next state: high pulse, equal gap, back-to-back if a note waits
  always_comb begin
    t_next   = t_state;
    cnt_next = cnt;
    case (t_state)
      T_IDLE: begin
        if (pend) begin
          t_next   = T_HIGH;
          cnt_next = CNT_LAST;
        end
      end
      T_HIGH: begin
        if (cnt == 8'd0) begin
          t_next   = T_GAP;
          cnt_next = CNT_LAST;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      T_GAP: begin
        if (cnt == 8'd0) begin
          t_next   = pend ? T_HIGH : T_IDLE;
          cnt_next = CNT_LAST;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: t_next = T_IDLE;
    endcase
  end

  // Trigger outputs: pulse level and the T_HIGH entry strobe
  always_comb begin
    trig = (t_state == T_HIGH);
    load = (t_next == T_HIGH) && (t_state != T_HIGH);
  end

  // Voice outputs only move on T_HIGH entry; note-off just drops note_active
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      note         <= 7'd0;
      velocity     <= 7'd0;
      delay_length <= RESET_DELAY;
      note_active  <= 1'b0;
    end else if (load) begin
      note         <= pd_note;
      velocity     <= pd_vel;
      delay_length <= pd_delay;
      note_active  <= 1'b1;
    end else if (off_hit) begin
      note_active  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_midi_kp_ctrl.sv
// tb/tb_midi_kp_ctrl.sv - self-checking bench for midi_kp_ctrl
module tb_midi_kp_ctrl;

  logic       a_clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] midi_chan;
  logic       omni;
  logic       trig;
  logic [6:0] velocity;
  logic [9:0] delay_length;
  logic [6:0] note;
  logic       note_active;

  midi_kp_ctrl dut (
    .a_clk(a_clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .midi_chan(midi_chan), .omni(omni), .trig(trig), .velocity(velocity),
    .delay_length(delay_length), .note(note), .note_active(note_active)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  // Reference model state, expressed as message timestamps
  int   m_s;
  logic m_pend;
  int   m_pd_note, m_pd_vel;
  int   e_note, e_vel, e_delay;
  logic e_active;
  logic m_rs, m_rs_on;
  int   m_exp, m_pn;
  logic m_mh, m_mon;
  int   m_mn, m_mv;

  function automatic int ref_delay(int n);
    int tbl[12] = '{734, 693, 654, 617, 582, 550, 519, 490, 462, 436, 412, 389};
    int k, o, d;
    if (n >= 48) begin
      k = (n - 48) % 12;
      o = (n - 48) / 12;
    end else begin
      k = n % 12;
      o = 0;
    end
    d = tbl[k] >> o;
    if (d < 8) d = 8;
    return d;
  endfunction

  task automatic model_reset();
    m_s = -1000; m_pend = 0; m_pd_note = 0; m_pd_vel = 0;
    e_note = 0; e_vel = 0; e_delay = 734; e_active = 0;
    m_rs = 0; m_rs_on = 0; m_exp = 0; m_pn = 0;
    m_mh = 0; m_mon = 0; m_mn = 0; m_mv = 0;
  endtask

  // One clock edge of the reference: a message is acted on one edge after it
  // completes; a waiting note fires once the previous pulse+gap window is over.
  task automatic model_step();
    logic ld, old_pend;
    int   old_pd_note, old_note;
    if (!reset_n) begin
      model_reset();
      return;
    end
    old_pend = m_pend; old_pd_note = m_pd_note; old_note = e_note;
    ld = m_pend && (cyc >= m_s + 32);
    if (ld) begin
      m_s = cyc; e_note = m_pd_note; e_vel = m_pd_vel;
      e_delay = ref_delay(m_pd_note); e_active = 1;
    end
    if (m_mh && m_mon) begin
      m_pend = 1; m_pd_note = m_mn; m_pd_vel = m_mv;
    end else begin
      if (ld) m_pend = 0;
      if (m_mh && old_pend && m_mn == old_pd_note) m_pend = 0;
      if (m_mh && m_mn == old_note && !ld) e_active = 0;
    end
    m_mh = 0;
    if (rx_valid && rx_data < 8'hF8) begin
      if (rx_data[7]) begin
        if (rx_data[7:5] == 3'b100 && (omni || rx_data[3:0] == midi_chan)) begin
          m_rs = 1; m_rs_on = rx_data[4]; m_exp = 1;
        end else begin
          m_rs = 0; m_exp = 0;
        end
      end else if (m_exp == 2) begin
        m_mh = 1; m_mn = m_pn; m_mv = int'(rx_data); m_mon = m_rs_on && rx_data != 0;
        m_exp = 0;
      end else if (m_exp == 1 || m_rs) begin
        m_pn = int'(rx_data); m_exp = 2;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_model();
    logic [25:0] act, exp;
    logic et;
    et = (cyc >= m_s) && (cyc < m_s + 16);
    act = {trig, note, velocity, delay_length, note_active};
    exp = {et, 7'(e_note), 7'(e_vel), 10'(e_delay), e_active};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model cycle %0d: got trig=%0b note=%0d vel=%0d dly=%0d act=%0b expected trig=%0b note=%0d vel=%0d dly=%0d act=%0b",
               cyc, trig, note, velocity, delay_length, note_active,
               et, e_note, e_vel, e_delay, e_active);
    end
  endtask

  // Drive inputs at the falling edge, advance one rising edge, sample 1 ns later
  task automatic tick(input logic v, input logic [7:0] d);
    @(negedge a_clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge a_clk);
    cyc++;
    model_step();
    #1;
    if (chk_en) compare_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(0, 8'h00);
    tick(0, 8'h00);
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic [39:0] b;
    logic [2:0]  n;
    logic [3:0]  ch;
    logic        om;
    logic        et;
    logic [6:0]  en;
    logic [6:0]  ev;
    logic [9:0]  ed;
  } vec_t;

  function automatic vec_t mk(logic [39:0] b, int n, int ch, logic om, logic et,
                              int en, int ev, int ed);
    vec_t v;
    v.b = b; v.n = 3'(n); v.ch = 4'(ch); v.om = om; v.et = et;
    v.en = 7'(en); v.ev = 7'(ev); v.ed = 10'(ed);
    return v;
  endfunction

  vec_t vt[10];

  initial begin
    int hi, s0, rises;
    logic prev;
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; midi_chan = 4'd0; omni = 1'b0;
    model_reset();

    vt[0] = mk(40'h9045640000, 3, 0,  0, 1, 69, 100, 218);
    vt[1] = mk(40'h9140400000, 3, 0,  0, 0, 0,  0,   734);
    vt[2] = mk(40'h9140400000, 3, 0,  1, 1, 64, 64,  291);
    vt[3] = mk(40'h90F830FE7F, 5, 0,  0, 1, 48, 127, 734);
    vt[4] = mk(40'h907F010000, 3, 0,  0, 1, 127, 1,  8);
    vt[5] = mk(40'h9F00100000, 3, 15, 0, 1, 0,  16,  734);
    vt[6] = mk(40'h9040000000, 3, 0,  0, 0, 0,  0,   734);
    vt[7] = mk(40'hB040400000, 3, 0,  0, 0, 0,  0,   734);
    vt[8] = mk(40'h903B220000, 3, 0,  0, 1, 59, 34,  389);
    vt[9] = mk(40'h9054050000, 3, 0,  0, 1, 84, 5,   91);

    do_reset();
    check("reset trig", trig, 0);
    check("reset note", note, 0);
    check("reset vel", velocity, 0);
    check("reset delay", delay_length, 734);
    check("reset active", note_active, 0);

    // Table vectors, each from reset
    for (int i = 0; i < 10; i++) begin
      midi_chan = vt[i].ch; omni = vt[i].om;
      do_reset();
      for (int j = 0; j < int'(vt[i].n); j++) begin
        logic [39:0] bb;
        bb = vt[i].b;
        tick(1, bb[39 - 8*j -: 8]);
      end
      tick(0, 8'h00);
      check($sformatf("vec%0d early trig", i), trig, 0);
      tick(0, 8'h00);
      check($sformatf("vec%0d trig", i), trig, vt[i].et);
      check($sformatf("vec%0d note", i), note, vt[i].en);
      check($sformatf("vec%0d vel", i), velocity, vt[i].ev);
      check($sformatf("vec%0d delay", i), delay_length, vt[i].ed);
      check($sformatf("vec%0d active", i), note_active, vt[i].et);
    end

    // Pulse width, gap and running-status note queued behind it
    midi_chan = 4'd0; omni = 1'b0;
    do_reset();
    tick(1, 8'h90); tick(1, 8'h45); tick(1, 8'h64);
    tick(0, 8'h00); tick(0, 8'h00);
    check("seqA first trig", trig, 1);
    hi = 1;
    for (int i = 1; i < 32; i++) begin
      if (i == 1)      tick(1, 8'h3C);
      else if (i == 2) tick(1, 8'h50);
      else             tick(0, 8'h00);
      if (trig) hi++;
    end
    check("seqA pulse width", hi, 16);
    check("seqA note held", note, 69);
    tick(0, 8'h00);
    check("seqA second trig", trig, 1);
    check("seqA second note", note, 60);
    check("seqA second delay", delay_length, 367);
    check("seqA second vel", velocity, 80);
    tick(1, 8'h80); tick(1, 8'h3C); tick(1, 8'h00);
    tick(0, 8'h00); tick(0, 8'h00);
    check("seqA note off", note_active, 0);

    // Velocity-0 note-on releases the held note without a new pulse
    do_reset();
    tick(1, 8'h90); tick(1, 8'h40); tick(1, 8'h40);
    for (int i = 0; i < 40; i++) tick(0, 8'h00);
    check("seqB held", note_active, 1);
    tick(1, 8'h40); tick(1, 8'h00);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 8'h00);
      if (trig) hi++;
    end
    check("seqB no trig", hi, 0);
    check("seqB released", note_active, 0);

    // Note-off for the pending note cancels it
    do_reset();
    tick(1, 8'h90); tick(1, 8'h45); tick(1, 8'h64);
    tick(0, 8'h00); tick(0, 8'h00);
    tick(1, 8'h3C); tick(1, 8'h50); tick(1, 8'h80); tick(1, 8'h3C); tick(1, 8'h00);
    rises = 0; prev = trig;
    for (int i = 0; i < 50; i++) begin
      tick(0, 8'h00);
      if (trig && !prev) rises++;
      prev = trig;
    end
    check("seqD cancelled", rises, 0);
    check("seqD note", note, 69);

    // Reset in the middle of a pulse with a byte arriving the same cycle
    do_reset();
    tick(1, 8'h90); tick(1, 8'h45); tick(1, 8'h64);
    tick(0, 8'h00); tick(0, 8'h00);
    for (int i = 0; i < 5; i++) tick(0, 8'h00);
    check("seqC trig before reset", trig, 1);
    reset_n = 1'b0;
    tick(1, 8'h90);
    check("seqC trig", trig, 0);
    check("seqC note", note, 0);
    check("seqC vel", velocity, 0);
    check("seqC delay", delay_length, 734);
    check("seqC active", note_active, 0);
    reset_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1, 8'h30);
      if (trig) hi++;
    end
    check("seqC no stale trig", hi, 0);

    // Randomized stream against the reference model
    midi_chan = 4'($urandom_range(0, 15));
    omni = 1'b0;
    do_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      int r;
      logic [7:0] b;
      int notes[6] = '{60, 62, 64, 127, 48, 30};
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 199) == 0) omni = ~omni;
      if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      if (r < 45) begin
        tick(0, 8'($urandom_range(0, 255)));
      end else begin
        if (r < 55)
          b = {3'b100, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) != 0) ? midi_chan : 4'($urandom_range(0, 15))};
        else if (r < 59)
          b = 8'($urandom_range(8'hA0, 8'hF7));
        else if (r < 64)
          b = 8'($urandom_range(8'hF8, 8'hFF));
        else if ($urandom_range(0, 4) == 0)
          b = 8'h00;
        else
          b = 8'(notes[$urandom_range(0, 5)]);
        tick(1, b);
      end
    end
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
